// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one magnitude comparator between two requesters.
//   Port 0 is the ID-stage branch resolver, port 1 the trap/set-on-compare unit.
//   Round-robin grant, one compare per cycle, result registered into a
//   one-entry response buffer per port (1-cycle latency from handshake).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_valid/req_ready  per-port request handshake (req_ready = one-hot grant)
//   req_a*/req_b*        per-port operands
//   req_op*              compare op: 0 EQ,1 NE,2 LT,3 LE,4 GT,5 GE,6 LTZ,7 GEZ
//   req_sgn              per-port signed select (affects LT/LE/GT/GE only)
//   rsp_valid/rsp_ready  per-port response handshake
//   rsp_res              per-port result bit
//   pri                  round-robin priority pointer
//   busy                 any request pending or any response buffer full
module cmp_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic [1:0]       req_sgn,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [1:0]       rsp_res,
    output logic             pri,
    output logic             busy
);

    logic [1:0]       slot_free;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [OPW-1:0]   op_sel;
    logic             sgn_sel;
    logic             eq;
    logic             lt;
    logic             gt;
    logic             cmp_res;

    // A slot being drained this cycle can accept a new result at the same edge.
    assign slot_free = ~rsp_valid | rsp_ready;
    assign eligible  = req_valid & slot_free;

    always_comb begin
        grant = 2'b00;
        if (eligible == 2'b11) begin
            grant = pri ? 2'b10 : 2'b01;
        end else begin
            grant = eligible;
        end
    end

    assign req_ready = grant;
    assign busy      = (|req_valid) | (|rsp_valid);

    // Operand mux follows the grant; with no grant the result is unused.
    always_comb begin
        a_sel   = grant[1] ? req_a1  : req_a0;
        b_sel   = grant[1] ? req_b1  : req_b0;
        op_sel  = grant[1] ? req_op1 : req_op0;
        sgn_sel = grant[1] ? req_sgn[1] : req_sgn[0];
    end

    always_comb begin
        eq = (a_sel == b_sel);
        lt = sgn_sel ? ($signed(a_sel) < $signed(b_sel)) : (a_sel < b_sel);
        gt = sgn_sel ? ($signed(a_sel) > $signed(b_sel)) : (a_sel > b_sel);
        cmp_res = 1'b0;
        case (op_sel)
            OPW'(0): cmp_res = eq;
            OPW'(1): cmp_res = ~eq;
            OPW'(2): cmp_res = lt;
            OPW'(3): cmp_res = lt | eq;
            OPW'(4): cmp_res = gt;
            OPW'(5): cmp_res = gt | eq;
            OPW'(6): cmp_res = a_sel[WIDTH-1];   // LTZ is always signed
            OPW'(7): cmp_res = ~a_sel[WIDTH-1];  // GEZ is always signed
            default: cmp_res = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 2'b00;
            rsp_res   <= 2'b00;
            pri       <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    // New load wins over a same-cycle drain.
                    rsp_valid[i] <= 1'b1;
                    rsp_res[i]   <= cmp_res;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            // Pointer moves to the port that was not just served.
            if (|grant) begin
                pri <= grant[0];
            end
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: single requests, signedness, contention,
// back-pressure, zero-compare ops and asynchronous reset.
module tb_cmp_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]  req_op0, req_op1;
    logic [1:0]  req_sgn;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  rsp_res;
    logic        pri;
    logic        busy;

    int total = 0;
    int bad   = 0;

    cmp_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_sgn(req_sgn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .pri(pri), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single request on port p; checks grant, then result one cycle later.
    task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic s, input logic exp,
                          input string tag);
        if (p == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op; req_sgn[0] = s; req_valid = 2'b01;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op; req_sgn[1] = s; req_valid = 2'b10;
        end
        #1;
        chk({tag, "_rdy"}, {30'd0, req_ready}, (p == 0) ? 32'd1 : 32'd2);
        tick();
        req_valid = 2'b00;
        chk({tag, "_vld"}, {31'd0, rsp_valid[p]}, 32'd1);
        chk({tag, "_res"}, {31'd0, rsp_res[p]}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11; req_sgn = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_op0 = '0; req_op1 = '0;
        #12;
        chk("rst_vld",  {30'd0, rsp_valid}, 32'd0);
        chk("rst_res",  {30'd0, rsp_res},   32'd0);
        chk("rst_pri",  {31'd0, pri},       32'd0);
        chk("rst_busy", {31'd0, busy},      32'd0);
        chk("rst_rdy",  {30'd0, req_ready}, 32'd0);
        reset = 1'b0;
        tick();

        // Single request, EQ 5==5 signed
        do_req(0, 32'd5, 32'd5, 3'd0, 1'b1, 1'b1, "single");
        chk("single_pri", {31'd0, pri}, 32'd1);

        // Signedness on port 1: -1 < 1 signed, 0xFFFFFFFF < 1 unsigned is false
        do_req(1, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b1, 1'b1, "lt_s");
        do_req(1, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, "lt_u");
        chk("sgn_pri", {31'd0, pri}, 32'd0);
        tick();
        chk("drain_vld", {30'd0, rsp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy},      32'd0);

        // Contention: port0 3<4 LT -> 1, port1 9!=9 -> 0
        req_a0 = 32'd3; req_b0 = 32'd4; req_op0 = 3'd2; req_sgn = 2'b11;
        req_a1 = 32'd9; req_b1 = 32'd9; req_op1 = 3'd1;
        req_valid = 2'b11;
        #1;
        chk("cont_g0", {30'd0, req_ready}, 32'd1);
        tick();
        chk("cont_v0", {30'd0, rsp_valid}, 32'd1);
        chk("cont_r0", {31'd0, rsp_res[0]}, 32'd1);
        chk("cont_g1", {30'd0, req_ready}, 32'd2);
        tick();
        chk("cont_v1", {30'd0, rsp_valid}, 32'd2);
        chk("cont_r1", {31'd0, rsp_res[1]}, 32'd0);
        chk("cont_g2", {30'd0, req_ready}, 32'd1);
        tick();
        chk("cont_v2", {30'd0, rsp_valid}, 32'd1);
        chk("cont_g3", {30'd0, req_ready}, 32'd2);
        tick();
        chk("cont_v3", {30'd0, rsp_valid}, 32'd2);
        chk("cont_pri", {31'd0, pri}, 32'd0);
        req_valid = 2'b00;
        tick();
        chk("cont_drain", {30'd0, rsp_valid}, 32'd0);

        // Back-pressure: park a 1 in port 0 with rsp_ready[0]=0
        rsp_ready = 2'b10;
        do_req(0, 32'd1, 32'd2, 3'd2, 1'b1, 1'b1, "bp_load");
        chk("bp_pri", {31'd0, pri}, 32'd1);
        req_a0 = 32'd5; req_b0 = 32'd2; req_op0 = 3'd2;   // new port0 result would be 0
        req_a1 = 32'd2; req_b1 = 32'd7; req_op1 = 3'd2;   // port1 result 1
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_gnt1", {30'd0, req_ready}, 32'd2);
            tick();
            chk("bp_hold_res", {31'd0, rsp_res[0]},   32'd1);
            chk("bp_hold_vld", {31'd0, rsp_valid[0]}, 32'd1);
            chk("bp_p1_res",   {31'd0, rsp_res[1]},   32'd1);
        end
        chk("bp_pri0", {31'd0, pri}, 32'd0);
        rsp_ready = 2'b11;
        #1;
        chk("bp_gnt0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        chk("bp_new_vld", {31'd0, rsp_valid[0]}, 32'd1);
        chk("bp_new_res", {31'd0, rsp_res[0]},   32'd0);
        chk("bp_new_pri", {31'd0, pri},          32'd1);
        tick();

        // Zero compares ignore b and sgn; plus unsigned/signed GE and EQ
        do_req(0, 32'h8000_0000, 32'd5,          3'd6, 1'b0, 1'b1, "ltz_neg_u");
        do_req(0, 32'h8000_0000, 32'd0,          3'd6, 1'b1, 1'b1, "ltz_neg_s");
        do_req(0, 32'd0,         32'h8000_0000,  3'd7, 1'b0, 1'b1, "gez_zero");
        do_req(0, 32'd7,         32'hFFFF_FFFF,  3'd6, 1'b1, 1'b0, "ltz_pos_s");
        do_req(0, 32'd7,         32'd0,          3'd6, 1'b0, 1'b0, "ltz_pos_u");
        do_req(0, 32'h8000_0000, 32'd0,          3'd7, 1'b0, 1'b0, "gez_neg");
        do_req(1, 32'hFFFF_FFFF, 32'd1,          3'd5, 1'b1, 1'b0, "ge_s");
        do_req(1, 32'hFFFF_FFFF, 32'd1,          3'd5, 1'b0, 1'b1, "ge_u");
        do_req(1, 32'hFFFF_FFFF, 32'd1,          3'd3, 1'b0, 1'b0, "le_u");
        do_req(0, 32'h8000_0000, 32'h8000_0000,  3'd0, 1'b0, 1'b1, "eq_u");
        do_req(1, 32'h1234_5678, 32'h1234_5678,  3'd1, 1'b1, 1'b0, "ne_s");
        do_req(1, 32'd3,         32'hFFFF_FFFE,  3'd4, 1'b1, 1'b1, "gt_s");
        tick();

        // Async reset with both buffers full and pri=1
        rsp_ready = 2'b00;
        do_req(1, 32'd1, 32'd1, 3'd0, 1'b0, 1'b1, "ar_p1");
        do_req(0, 32'd1, 32'd2, 3'd2, 1'b0, 1'b1, "ar_p0");
        chk("ar_pre_vld", {30'd0, rsp_valid}, 32'd3);
        chk("ar_pre_pri", {31'd0, pri},       32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_vld",  {30'd0, rsp_valid}, 32'd0);
        chk("ar_res",  {30'd0, rsp_res},   32'd0);
        chk("ar_pri",  {31'd0, pri},       32'd0);
        chk("ar_busy", {31'd0, busy},      32'd0);
        chk("ar_rdy",  {30'd0, req_ready}, 32'd0);
        #3;
        reset = 1'b0;
        tick();
        chk("post_vld", {30'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares a single signed/unsigned magnitude comparator between two requesters: port 0 is the ID-stage branch resolver and port 1 is the trap/set-on-compare unit.
- Arbitrates round-robin, performs one compare per cycle, and returns a registered 1-bit result per port.
- Each port has a one-entry response buffer with a valid/ready handshake on both sides.
- Sits between the decode/hazard logic and the comparator resource.

Parameters:
- WIDTH, 32, operand width in bits.
- OPW, 3, width of the compare-op code.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req_valid  input  2  per-port request valid; bit i belongs to port i.
- req_ready  output  2  per-port request accepted this cycle.
- req_a0, req_b0  input  WIDTH each  port 0 operands.
- req_a1, req_b1  input  WIDTH each  port 1 operands.
- req_op0, req_op1  input  OPW each  compare-op code for each port.
- req_sgn  input  2  per-port flag; 1 = signed compare, 0 = unsigned.
- rsp_valid  output  2  per-port result valid.
- rsp_ready  input  2  per-port consumer ready.
- rsp_res  output  2  per-port result bit.
- pri  output  1  current round-robin priority pointer (0 or 1).
- busy  output  1  high when any request is pending or any response buffer is full.

Behaviour:
- Reset (asynchronous): rsp_valid=0, rsp_res=0, pri=0. Outputs derived from these are also forced, so busy=0 and req_ready=0 while no request is pending.
- Op codes:
  - 0 EQ (a==b), 1 NE, 2 LT, 3 LE, 4 GT, 5 GE.
  - 6 LTZ (a<0), 7 GEZ (a>=0); both always signed and ignore b.
  - req_sgn selects a signed or unsigned interpretation for ops 2-5 only; EQ/NE are unaffected.
- Slot free:
  - free[i] = ~rsp_valid[i] | rsp_ready[i].
  - This includes a response being drained in the same cycle.
- Eligibility: eligible[i] = req_valid[i] & free[i].
- Grant (combinational):
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port equal to pri is granted.
  - At most one grant per cycle.
  - req_ready = one-hot grant, or 0 when nothing is granted.
- Priority pointer: on any grant to port g, pri becomes ~g at the next edge. With no grant, pri holds.
- Compare:
  - The comparator is evaluated on the granted port's operands in the grant cycle.
  - The result is registered into rsp_res[g], and rsp_valid[g] is set at the next edge.
  - Latency is exactly 1 cycle from handshake to rsp_valid.
- Response buffer, evaluated per port each edge:
  - A new grant loads a new result and keeps valid=1, even if a drain happens in the same cycle.
  - A drain with no new grant clears valid.
  - Otherwise the buffer holds; rsp_res stays stable while rsp_valid=1 and rsp_ready=0.
- Requester obligations:
  - Hold operands, op and sgn stable while req_valid=1 and req_ready=0.
  - req_valid may be dropped without a handshake; no state changes.
- Back-pressure:
  - A port whose buffer is full and not draining is never granted.
  - The other port may be granted in that cycle regardless of pri, and pri updates normally.
- Starvation: when both ports are continuously eligible, grants alternate 0,1,0,1… with no port waiting more than 1 cycle.
- busy = |req_valid | |rsp_valid.
- Reset mid-operation: pending results are discarded and no response is emitted for the in-flight grant. Requesters must re-issue after reset.
- Width rules: signed compare treats bit WIDTH-1 as the sign; no operand extension is performed.

Test Plan:
- Single request: port 0, a=5, b=5, op=EQ, sgn=1. Required: req_ready=2'b01 in cycle 0; rsp_valid[0]=1 and rsp_res[0]=1 in cycle 1; pri=1.
- Signedness: port 1, a=32'hFFFF_FFFF, b=1, op=LT. With sgn=1, rsp_res[1]=1; repeated with sgn=0, rsp_res[1]=0.
- Contention: both valid for 4 cycles with rsp_ready=2'b11 and pri=0 at start. Required grants are 01,10,01,10; each result appears 1 cycle after its grant.
- Back-pressure: port 0 result held with rsp_ready[0]=0 while req_valid=2'b11 for 3 cycles.
  - Required: port 1 granted every cycle and port 0 never granted.
  - rsp_res[0] stays constant.
  - When rsp_ready[0] rises, port 0 is granted in that same cycle and rsp_valid[0] remains 1 with the new result.
- Zero-compare ops: a=32'h8000_0000, op=LTZ gives 1; a=0, op=GEZ gives 1; a=7, op=LTZ gives 0. These results must be independent of b and sgn.
- Async reset: assert reset mid-cycle with rsp_valid=2'b11 and pri=1. Required: outputs clear immediately, with rsp_valid=0, pri=0 and busy=0 (req_valid held low), before the next clk edge.
